// File: rtl/s_skid_reg.sv
// -----------------------------------------------------------------------------
// s_skid_reg
//
// Purpose:
//   Two-entry valid/ready skid register. It registers the upstream ready so
//   that no combinational path runs from ordy back to irdy, while still
//   sustaining one word per clock. The main register drives odat/ovld. The
//   skid register catches the one word that can arrive in the cycle where the
//   consumer stalls.
//
// Parameters:
//   SIZE     data width in bits
//   RST_VAL  reset value of odat and of the internal skid word
//
// Ports:
//   clk       in   1     clock, all state updates on posedge
//   rst       in   1     synchronous reset, active-high
//   ivld      in   1     upstream word valid
//   irdy      out  1     upstream ready (transfer on ivld & irdy)
//   idat      in   SIZE  upstream data
//   ovld      out  1     downstream word valid
//   ordy      in   1     downstream ready (transfer on ovld & ordy)
//   odat      out  SIZE  downstream data
//   stat_cnt  out  32    accepted-word count (only with S_SKID_REG_STAT_EN)
//
// Configuration macro:
//   S_SKID_REG_STAT_EN  when defined, adds the stat_cnt port and its counter.
// -----------------------------------------------------------------------------
module s_skid_reg #(
  parameter int unsigned     SIZE    = 8,
  parameter logic [SIZE-1:0] RST_VAL = {SIZE{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ivld,
  output logic            irdy,
  input  logic [SIZE-1:0] idat,
  output logic            ovld,
  input  logic            ordy,
  output logic [SIZE-1:0] odat
`ifdef S_SKID_REG_STAT_EN
  ,
  output logic [31:0]     stat_cnt
`endif
);

  // The state encoding is {main_vld, skid_vld}. The skid register can only
  // hold a word while main also holds one, so 2'b01 never occurs.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SIZE-1:0] skid;
  logic            main_vld;
  logic            skid_vld;
  logic            in_fire;
  logic            out_fire;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;

  assign main_vld = state[1];
  assign skid_vld = state[0];

  // Ready comes only from the flops and rst. It never depends on ordy or
  // ivld, so there is no combinational path through this block.
  assign irdy     = ~skid_vld & ~rst;
  assign ovld     = main_vld;
  assign in_fire  = ivld & irdy;
  assign out_fire = main_vld & ordy;

  // Next-state and register-load decode. The defaults keep the occupancy and
  // hold both data registers. Each branch then names the single move that the
  // handshakes call for in that state.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // In FULL, irdy is low. The parked word moves into main as soon as
        // the consumer takes the current main word.
        if (ordy) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State and data registers. Reset discards any words held in the block.
  // While ovld is low, odat keeps its last value; consumers qualify it with
  // ovld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      odat  <= RST_VAL;
      skid  <= RST_VAL;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        odat <= idat;
      end else if (load_main_skid) begin
        odat <= skid;
      end
      if (load_skid) begin
        skid <= idat;
      end
    end
  end

`ifdef S_SKID_REG_STAT_EN
  // Accepted-word counter. It increments on every upstream handshake and
  // wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= 32'd0;
    end else if (in_fire) begin
      stat_cnt <= stat_cnt + 32'd1;
    end
  end
`else
  // Statistics are disabled in this build: no counter and no stat_cnt port.
  // The datapath is unchanged.
`endif

endmodule

// File: tb/tb_s_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_s_skid_reg
//
// Purpose:
//   Self-checking bench for s_skid_reg. The stimulus drives directed vectors
//   and pushes every accepted word into a scoreboard queue. A monitor on the
//   falling edge pops words and compares them whenever the DUT hands a word
//   downstream. The monitor also checks irdy/ovld against the occupancy the
//   queue implies, and checks that odat stays stable during stalls.
//
// Ports: none (top-level bench). Build with S_SKID_REG_STAT_EN defined to
//   exercise the accepted-word counter as well.
// -----------------------------------------------------------------------------
module tb_s_skid_reg;

  localparam int unsigned SIZE = 8;

  logic            clk;
  logic            rst;
  logic            ivld;
  logic            irdy;
  logic [SIZE-1:0] idat;
  logic            ovld;
  logic            ordy;
  logic [SIZE-1:0] odat;
`ifdef S_SKID_REG_STAT_EN
  logic [31:0]     stat_cnt;
`endif

  int              tests;
  int              fails;
  int              push_cnt;
  bit              mon_en;
  bit              stall_prev;
  logic [SIZE-1:0] prev_odat;
  logic [SIZE-1:0] sb[$];

  s_skid_reg #(.SIZE(SIZE), .RST_VAL(8'h00)) dut (
    .clk  (clk),
    .rst  (rst),
    .ivld (ivld),
    .irdy (irdy),
    .idat (idat),
    .ovld (ovld),
    .ordy (ordy),
    .odat (odat)
`ifdef S_SKID_REG_STAT_EN
    ,
    .stat_cnt (stat_cnt)
`endif
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every check in the bench goes through here.
  function automatic void check_output(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs just after the rising edge.
  task automatic apply_stimulus(input logic v, input logic [SIZE-1:0] d, input logic r);
    @(posedge clk);
    #1;
    ivld = v;
    idat = d;
    ordy = r;
  endtask

  // Monitor. On the falling edge the inputs and outputs are stable. The
  // monitor compares them against the scoreboard occupancy, then records the
  // handshakes that the next rising edge will perform.
  always @(negedge clk) begin
    if (mon_en) begin
      check_output("irdy", {31'd0, irdy}, {31'd0, (!rst && sb.size() < 2)});
      check_output("ovld", {31'd0, ovld}, {31'd0, (sb.size() != 0)});
      if (stall_prev) begin
        check_output("stall_odat", {24'd0, odat}, {24'd0, prev_odat});
      end
      if (!rst && ovld && ordy) begin
        if (sb.size() == 0) begin
          check_output("spurious_word", {24'd0, odat}, 32'hFFFF_FFFF);
        end else begin
          check_output("odat", {24'd0, odat}, {24'd0, sb.pop_front()});
        end
      end
      if (!rst && ivld && irdy) begin
        sb.push_back(idat);
        push_cnt++;
      end
      stall_prev = !rst && ovld && !ordy;
      prev_odat  = odat;
      if (rst) begin
        sb.delete();
      end
    end
  end

  // Run with ordy held high until the scoreboard is empty. A fixed cycle
  // budget keeps the run bounded.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      apply_stimulus(1'b0, 8'h00, 1'b1);
      n++;
    end
    @(negedge clk);
    check_output("drain_done", sb.size(), 0);
  endtask

  initial begin
    int base;
    int cyc;
    tests      = 0;
    fails      = 0;
    push_cnt   = 0;
    mon_en     = 1'b0;
    stall_prev = 1'b0;
    prev_odat  = '0;
    rst        = 1'b1;
    ivld       = 1'b1;
    idat       = 8'hAA;
    ordy       = 1'b0;

    // Hold reset for 3 clocks while a word is offered. The word must not be
    // taken.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("rst_ovld", {31'd0, ovld}, 32'd0);
      check_output("rst_irdy", {31'd0, irdy}, 32'd0);
      check_output("rst_odat", {24'd0, odat}, 32'h00);
    end
    @(posedge clk);
    #1;
    rst  = 1'b0;
    ivld = 1'b0;
    @(negedge clk);
    check_output("rel_irdy", {31'd0, irdy}, 32'd1);
    check_output("rel_ovld", {31'd0, ovld}, 32'd0);

    // Back-to-back streaming with the consumer always ready.
    for (int i = 1; i <= 16; i++) begin
      apply_stimulus(1'b1, i[7:0], 1'b1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_output("stream_last", {24'd0, odat}, 32'h10);
    drain();

    // Backpressure: two words with the consumer stalled fill the block.
    apply_stimulus(1'b1, 8'h11, 1'b0);
    apply_stimulus(1'b1, 8'h22, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("bp_ovld", {31'd0, ovld}, 32'd1);
    check_output("bp_odat", {24'd0, odat}, 32'h11);
    check_output("bp_irdy", {31'd0, irdy}, 32'd0);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_output("bp_second", {24'd0, odat}, 32'h22);
    check_output("bp_irdy_back", {31'd0, irdy}, 32'd1);
    drain();

    // Reset while FULL. Both parked words must be discarded.
    apply_stimulus(1'b1, 8'h33, 1'b0);
    apply_stimulus(1'b1, 8'h44, 1'b0);
    apply_stimulus(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check_output("pre_rst_full", {31'd0, irdy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    check_output("midrst_ovld", {31'd0, ovld}, 32'd0);
    check_output("midrst_odat", {24'd0, odat}, 32'h00);
    repeat (4) apply_stimulus(1'b0, 8'h00, 1'b1);

    // Random valid/ready traffic. The monitor checks order, loss,
    // duplication and stall stability.
    base = push_cnt;
    cyc  = 0;
    while (push_cnt < base + 10000 && cyc < 60000) begin
      apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
      cyc++;
    end
    check_output("random_words", push_cnt - base, 10000);
    drain();

`ifdef S_SKID_REG_STAT_EN
    // Accepted-word counter: count five words, then check the 32-bit wrap.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 8'(i + 8'h50), 1'b1);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_output("stat_five", stat_cnt, 32'd5);
    @(posedge clk);
    #1;
    force dut.stat_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stat_cnt;
    apply_stimulus(1'b1, 8'h61, 1'b1);
    apply_stimulus(1'b1, 8'h62, 1'b1);
    apply_stimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_output("stat_wrap", stat_cnt, 32'd1);
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
